alu_result_skid: RTL and testbench

- Execute-to-memory stage directly downstream of the 32-bit ALU.
- Registers the ALU result, the zero/negative flags and the destination register tag.
- Resolves the branch condition from the flags.
- Hands results to the memory/writeback stage through a valid/ready handshake. A 2-entry skid buffer keeps full throughput under backpressure and never loses a result.

---
 rtl/alu_result_skid_if.sv | 37 +++
 rtl/alu_result_skid.sv | 143 ++++++++++++++
 tb/tb_alu_result_skid.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_skid_if.sv
// alu_result_skid_if: handshake and data bundle between the ALU, the
// execute-to-memory skid stage and the memory/writeback stage.
// master = the environment around the stage, slave = the stage itself.
interface alu_result_skid_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      in_valid_i;
    logic                      in_ready_o;
    logic [DATA_WIDTH-1:0]     alu_data_i;
    logic                      alu_zero_i;
    logic                      alu_negative_i;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_i;
    logic                      reg_write_i;
    logic [1:0]                br_type_i;
    logic                      flush_i;
    logic                      out_valid_o;
    logic                      out_ready_i;
    logic [DATA_WIDTH-1:0]     out_data_o;
    logic [REG_ADDR_WIDTH-1:0] out_rd_addr_o;
    logic                      out_reg_write_o;
    logic                      out_branch_taken_o;

    modport master (
        output in_valid_i, alu_data_i, alu_zero_i, alu_negative_i,
               rd_addr_i, reg_write_i, br_type_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_rd_addr_o,
               out_reg_write_o, out_branch_taken_o
    );

    modport slave (
        input  in_valid_i, alu_data_i, alu_zero_i, alu_negative_i,
               rd_addr_i, reg_write_i, br_type_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_rd_addr_o,
               out_reg_write_o, out_branch_taken_o
    );
endinterface

// File: rtl/alu_result_skid.sv
// alu_result_skid: execute-to-memory stage behind the ALU. Captures the ALU
// result, destination tag and resolved branch condition into a 2-entry skid
// buffer (main + skid) so the valid/ready handshake keeps full throughput
// under backpressure without dropping results.
// Optional feature: define ALU_RESULT_SKID_STALL_CNT_EN to add stall_cnt_o,
// a saturating count of cycles where the output was valid but not accepted.
module alu_result_skid #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    alu_result_skid_if.slave    bus
`ifdef ALU_RESULT_SKID_STALL_CNT_EN
    ,
    output logic [15:0]         stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     data;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      we;
        logic                      taken;
    } entry_t;

    state_e state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   in_ready;
    logic   out_valid;
    logic   in_xfer;
    logic   out_xfer;

    // Ready depends only on the skid slot being free, so it never loops
    // combinationally through the downstream ready.
    assign in_ready  = rst_ni & (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign in_xfer   = bus.in_valid_i & in_ready;
    assign out_xfer  = out_valid & bus.out_ready_i;

    assign bus.in_ready_o         = in_ready;
    assign bus.out_valid_o        = out_valid;
    assign bus.out_data_o         = main_q.data;
    assign bus.out_rd_addr_o      = main_q.rd;
    assign bus.out_reg_write_o    = out_valid & main_q.we;
    assign bus.out_branch_taken_o = out_valid & main_q.taken;

    // Package the incoming result and resolve its branch from the ALU flags.
    always_comb begin
        in_entry.data  = bus.alu_data_i;
        in_entry.rd    = bus.rd_addr_i;
        in_entry.we    = bus.reg_write_i;
        in_entry.taken = 1'b0;
        case (bus.br_type_i)
            2'b01:   in_entry.taken = bus.alu_zero_i;
            2'b10:   in_entry.taken = ~bus.alu_zero_i;
            2'b11:   in_entry.taken = bus.alu_negative_i;
            default: in_entry.taken = 1'b0;
        endcase
    end

    // Next-state and entry moves; a flush empties the buffer but leaves the
    // main fields alone so out_data_o keeps its last value.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_d  = in_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_entry;
                    end else if (in_xfer) begin
                        skid_d  = in_entry;
                        state_d = TWO;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and both entries, cleared to zero by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef ALU_RESULT_SKID_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Count stalled cycles, saturating; flush does not touch the count.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !bus.out_ready_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_result_skid.sv
// tb_alu_result_skid: randomized and directed bench for alu_result_skid,
// checked against a queue-based model of the stage. Define
// ALU_RESULT_SKID_STALL_CNT_EN to also check stall_cnt_o.
module tb_alu_result_skid;

    localparam int DW  = 32;
    localparam int RAW = 5;

    logic clk_i = 1'b0;
    logic rst_ni;

    alu_result_skid_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW)) bus ();

`ifdef ALU_RESULT_SKID_STALL_CNT_EN
    logic [15:0] stall_cnt_o;
`endif

    alu_result_skid #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .bus         (bus)
`ifdef ALU_RESULT_SKID_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0]  data;
        logic [RAW-1:0] rd;
        logic           we;
        logic           taken;
    } ref_t;

    ref_t           refQ[$];
    logic [DW-1:0]  refLastData;
    logic [RAW-1:0] refLastRd;
    int             refStall;
    int             vectors;
    int             miscompares;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic refTaken(input logic [1:0] br, input logic zero,
                                      input logic neg);
        case (br)
            2'b01:   return zero;
            2'b10:   return !zero;
            2'b11:   return neg;
            default: return 1'b0;
        endcase
    endfunction

    task automatic checkAll(input string tag);
        bit hasEntry;
        hasEntry = (refQ.size() > 0);
        checkOutput({tag, ".valid"}, bus.out_valid_o, hasEntry);
        checkOutput({tag, ".data"}, bus.out_data_o, refLastData);
        checkOutput({tag, ".rd"}, bus.out_rd_addr_o, refLastRd);
        checkOutput({tag, ".we"}, bus.out_reg_write_o, hasEntry ? refQ[0].we : 1'b0);
        checkOutput({tag, ".taken"}, bus.out_branch_taken_o,
                    hasEntry ? refQ[0].taken : 1'b0);
`ifdef ALU_RESULT_SKID_STALL_CNT_EN
        checkOutput({tag, ".stall"}, stall_cnt_o, refStall);
`endif
    endtask

    // One clock cycle: drive inputs, check ready, advance the model, check outputs.
    task automatic applyStimulus(input string tag, input logic rst, input logic inValid,
                                 input logic [DW-1:0] data, input logic zero,
                                 input logic neg, input logic [RAW-1:0] rd,
                                 input logic we, input logic [1:0] br,
                                 input logic flush, input logic outReady);
        bit   inXfer;
        bit   outXfer;
        bit   stallNow;
        ref_t entry;
        rst_ni             = rst;
        bus.in_valid_i     = inValid;
        bus.alu_data_i     = data;
        bus.alu_zero_i     = zero;
        bus.alu_negative_i = neg;
        bus.rd_addr_i      = rd;
        bus.reg_write_i    = we;
        bus.br_type_i      = br;
        bus.flush_i        = flush;
        bus.out_ready_i    = outReady;
        #1;
        checkOutput({tag, ".in_ready"}, bus.in_ready_o, rst && (refQ.size() < 2));
        inXfer   = rst && inValid && (refQ.size() < 2);
        outXfer  = (refQ.size() > 0) && outReady;
        stallNow = (refQ.size() > 0) && !outReady;
        entry.data  = data;
        entry.rd    = rd;
        entry.we    = we;
        entry.taken = refTaken(br, zero, neg);
        @(posedge clk_i);
        if (!rst) begin
            refQ.delete();
            refLastData = '0;
            refLastRd   = '0;
            refStall    = 0;
        end else begin
            if (stallNow && refStall < 65535) refStall++;
            if (flush) begin
                refQ.delete();
            end else begin
                if (outXfer) void'(refQ.pop_front());
                if (inXfer) refQ.push_back(entry);
            end
        end
        if (refQ.size() > 0) begin
            refLastData = refQ[0].data;
            refLastRd   = refQ[0].rd;
        end
        #1;
        checkAll(tag);
    endtask

    task automatic idle(input string tag, input logic outReady);
        applyStimulus(tag, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 2'b00, 1'b0, outReady);
    endtask

    task automatic send(input string tag, input logic [DW-1:0] data, input logic outReady);
        applyStimulus(tag, 1'b1, 1'b1, data, 1'b0, 1'b0, data[RAW-1:0], 1'b1, 2'b00,
                      1'b0, outReady);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        refLastData = '0;
        refLastRd   = '0;
        refStall    = 0;

        // Reset held two cycles with a valid input pending
        applyStimulus("reset0", 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 5'd7, 1'b1, 2'b01, 1'b0, 1'b1);
        applyStimulus("reset1", 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 5'd7, 1'b1, 2'b01, 1'b0, 1'b1);
        checkOutput("reset.data_zero", bus.out_data_o, 32'h0);
        idle("post_reset", 1'b1);
        checkOutput("post_reset.ready", bus.in_ready_o, 1'b1);

        // Streaming at full rate
        send("stream11", 32'h11, 1'b1);
        checkOutput("stream.first", bus.out_data_o, 32'h11);
        send("stream22", 32'h22, 1'b1);
        send("stream33", 32'h33, 1'b1);
        idle("stream_drain", 1'b1);

        // Backpressure fills both entries, then drains in order
        send("bpA0", 32'hA0, 1'b0);
        send("bpB0", 32'hB0, 1'b0);
        checkOutput("bp.ready_low", bus.in_ready_o, 1'b0);
        send("bpC0_held", 32'hC0, 1'b0);
        send("bpC0_drain1", 32'hC0, 1'b1);
        checkOutput("bp.second", bus.out_data_o, 32'hB0);
        send("bpC0_drain2", 32'hC0, 1'b1);
        checkOutput("bp.third", bus.out_data_o, 32'hC0);
        idle("bp_drain", 1'b1);
        idle("bp_empty", 1'b1);

        // Branch resolution
        applyStimulus("beq_z1", 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 5'd1, 1'b0, 2'b01, 1'b0, 1'b1);
        checkOutput("beq.taken", bus.out_branch_taken_o, 1'b1);
        applyStimulus("bne_z1", 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 5'd2, 1'b0, 2'b10, 1'b0, 1'b1);
        applyStimulus("blt_n1", 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd3, 1'b1, 2'b11, 1'b0, 1'b1);
        checkOutput("blt.taken", bus.out_branch_taken_o, 1'b1);
        applyStimulus("none", 1'b1, 1'b1, 32'h5, 1'b1, 1'b1, 5'd4, 1'b1, 2'b00, 1'b0, 1'b1);
        idle("br_drain", 1'b1);

        // Flush in TWO while a new input is offered
        send("fl_fill1", 32'h1, 1'b0);
        send("fl_fill2", 32'h2, 1'b0);
        applyStimulus("flush", 1'b1, 1'b1, 32'h55, 1'b0, 1'b0, 5'd5, 1'b1, 2'b00, 1'b1, 1'b0);
        checkOutput("flush.ready", bus.in_ready_o, 1'b1);
        idle("fl_idle1", 1'b1);
        idle("fl_idle2", 1'b1);

        // Reset while full with downstream ready
        send("rs_fill1", 32'h77, 1'b0);
        send("rs_fill2", 32'h88, 1'b0);
        applyStimulus("mid_reset", 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 2'b00, 1'b0, 1'b1);
        idle("rs_idle1", 1'b1);
        idle("rs_idle2", 1'b1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] r;
            r = $urandom;
            applyStimulus("rand",
                          ($urandom_range(63) != 0),
                          r[0],
                          $urandom,
                          r[1],
                          r[2],
                          r[7:3],
                          r[8],
                          r[10:9],
                          ($urandom_range(15) == 0),
                          ($urandom_range(9) < 6));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
